// File: rtl/filter_frame_scheduler_pkg.sv
// Shared state encoding, mode codes and a constant-friendly clog2 for the filter frame scheduler.
package filter_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] MOD_OFF   = 3'b000;
    localparam logic [2:0] MOD_GAUSS = 3'b001;
    localparam logic [2:0] MOD_SHARP = 3'b010;
    localparam logic [2:0] MOD_LAPL  = 3'b100;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic mod_legal(input logic [2:0] m);
        return (m == MOD_OFF) || (m == MOD_GAUSS) || (m == MOD_SHARP) || (m == MOD_LAPL);
    endfunction

endpackage

// File: rtl/filter_frame_scheduler.sv
// Sequences weight loads and frame processing for the 3x3 filter; mode changes land only between frames.
// Accept-to-LOAD is 2 cycles; mod_req_ready drops while a request is pending or taps are loading.
module filter_frame_scheduler
    import filter_frame_scheduler_pkg::*;
#(
    parameter int COLS  = 640,
    parameter int ROWS  = 480,
    parameter int NTAPS = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   mod_req,
    input  logic                         mod_req_valid,
    output logic                         mod_req_ready,
    input  logic                         frame_start,
    input  logic                         data_out_valid,
    output logic [2:0]                   mod,
    output logic                         weight_in_valid,
    output logic [3:0]                   weight_addr,
    output logic                         process_enable,
    output logic                         frame_done,
    output logic [clog2(COLS*ROWS):0]    pix_cnt,
    output logic                         err_illegal_mod
);

    localparam int TOTAL = COLS * ROWS;
    localparam int PW    = clog2(TOTAL) + 1;

    state_t     state;
    state_t     state_nxt;
    logic       pend_valid;
    logic [2:0] pend_mod;
    logic [2:0] mod_nxt;
    logic       pend_take;
    logic [3:0] tap_cnt;
    logic       req_acc;
    logic       tap_last;

    assign mod_req_ready = !pend_valid && (state != ST_LOAD);
    assign req_acc       = mod_req_valid && mod_req_ready;
    assign tap_last      = (tap_cnt == 4'(NTAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mod_nxt         = mod;
        pend_take       = 1'b0;
        weight_in_valid = 1'b0;
        weight_addr     = 4'd0;
        process_enable  = 1'b0;
        frame_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    pend_take = 1'b1;
                    mod_nxt   = MOD_OFF;
                    if (pend_mod != MOD_OFF) begin
                        state_nxt = ST_LOAD;
                        mod_nxt   = pend_mod;
                    end
                end
            end
            ST_LOAD: begin
                weight_in_valid = 1'b1;
                weight_addr     = tap_cnt;
                if (tap_last) state_nxt = ST_ARMED;
            end
            ST_ARMED, ST_DONE: begin
                frame_done = (state == ST_DONE);
                // A frame start beats a pending mode change; ARMED otherwise holds
                if (state == ST_ARMED && frame_start) begin
                    state_nxt = ST_RUN;
                end else if (pend_valid) begin
                    pend_take = 1'b1;
                    if (pend_mod != MOD_OFF) begin
                        state_nxt = ST_LOAD;
                        mod_nxt   = pend_mod;
                    end else begin
                        state_nxt = ST_IDLE;
                        mod_nxt   = MOD_OFF;
                    end
                end else begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_RUN: begin
                process_enable = 1'b1;
                if (data_out_valid && pix_cnt == PW'(TOTAL - 1)) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mod             <= MOD_OFF;
            pend_valid      <= 1'b0;
            pend_mod        <= MOD_OFF;
            tap_cnt         <= 4'd0;
            pix_cnt         <= '0;
            err_illegal_mod <= 1'b0;
        end else begin
            mod <= mod_nxt;
            if (pend_take) pend_valid <= 1'b0;
            // Ready is low whenever pend_valid is set, so accept and consume never collide
            if (req_acc) begin
                if (mod_legal(mod_req)) begin
                    pend_valid <= 1'b1;
                    pend_mod   <= mod_req;
                end else begin
                    err_illegal_mod <= 1'b1;
                end
            end
            tap_cnt <= (state == ST_LOAD && !tap_last) ? tap_cnt + 4'd1 : 4'd0;
            if (state == ST_ARMED && frame_start) begin
                pix_cnt <= '0;
            end else if (state == ST_RUN && data_out_valid) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_frame_scheduler.sv
// Directed bench for filter_frame_scheduler using a reduced 40x30 frame.
module tb_filter_frame_scheduler;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int NTAPS = 9;
    localparam int TOTAL = COLS * ROWS;

    logic        clk;
    logic        rst;
    logic [2:0]  mod_req;
    logic        mod_req_valid;
    logic        mod_req_ready;
    logic        frame_start;
    logic        data_out_valid;
    logic [2:0]  mod;
    logic        weight_in_valid;
    logic [3:0]  weight_addr;
    logic        process_enable;
    logic        frame_done;
    logic [11:0] pix_cnt;
    logic        err_illegal_mod;

    int checks;
    int errors;
    int fd_early;

    filter_frame_scheduler #(.COLS(COLS), .ROWS(ROWS), .NTAPS(NTAPS)) dut (
        .clk            (clk),
        .rst            (rst),
        .mod_req        (mod_req),
        .mod_req_valid  (mod_req_valid),
        .mod_req_ready  (mod_req_ready),
        .frame_start    (frame_start),
        .data_out_valid (data_out_valid),
        .mod            (mod),
        .weight_in_valid(weight_in_valid),
        .weight_addr    (weight_addr),
        .process_enable (process_enable),
        .frame_done     (frame_done),
        .pix_cnt        (pix_cnt),
        .err_illegal_mod(err_illegal_mod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic load_check(input logic [2:0] exp_mod);
        for (int i = 0; i < NTAPS; i++) begin
            chkb("load_wiv", weight_in_valid, 1'b1);
            chk("load_addr", 32'(weight_addr), 32'(i));
            chk("load_mod", 32'(mod), 32'(exp_mod));
            chkb("load_fd", frame_done, 1'b0);
            chkb("load_ready", mod_req_ready, 1'b0);
            step();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mod", 32'(mod), 32'd0);
        chkb("rst_wiv", weight_in_valid, 1'b0);
        chk("rst_addr", 32'(weight_addr), 32'd0);
        chkb("rst_pe", process_enable, 1'b0);
        chkb("rst_fd", frame_done, 1'b0);
        chk("rst_pix", 32'(pix_cnt), 32'd0);
        chkb("rst_err", err_illegal_mod, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fd_early = 0;
        rst = 1'b1;
        mod_req = 3'b000;
        mod_req_valid = 1'b0;
        frame_start = 1'b0;
        data_out_valid = 1'b0;
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;
        step();
        chkb("ready_after_rst", mod_req_ready, 1'b1);

        // gaussian request: accepted, consumed next cycle, LOAD after that
        mod_req = 3'b001;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        chkb("ready_pending", mod_req_ready, 1'b0);
        chkb("idle_no_wiv", weight_in_valid, 1'b0);
        step();
        load_check(3'b001);
        chkb("armed_wiv", weight_in_valid, 1'b0);
        chk("armed_addr", 32'(weight_addr), 32'd0);
        chkb("armed_pe", process_enable, 1'b0);
        chk("armed_mod", 32'(mod), 32'd1);
        chkb("armed_ready", mod_req_ready, 1'b1);

        // illegal code: flagged, nothing else moves
        mod_req = 3'b011;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        chkb("illegal_err", err_illegal_mod, 1'b1);
        chk("illegal_mod", 32'(mod), 32'd1);
        chkb("illegal_wiv", weight_in_valid, 1'b0);
        chkb("illegal_ready", mod_req_ready, 1'b1);
        step();
        chkb("illegal_sticky", err_illegal_mod, 1'b1);
        chkb("illegal_pe", process_enable, 1'b0);

        // full frame with a mid-frame laplacian request and a stray frame_start
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chkb("run_pe", process_enable, 1'b1);
        chk("run_pix0", 32'(pix_cnt), 32'd0);
        for (int k = 0; k < TOTAL; k++) begin
            data_out_valid = 1'b1;
            mod_req_valid = (k == 100) || (k == 101);
            mod_req = (k == 100) ? 3'b100 : 3'b010;
            frame_start = (k == 500);
            if (k == 101) chkb("run_ready_pend", mod_req_ready, 1'b0);
            step();
            if (k < TOTAL - 1) fd_early += int'(frame_done);
            if (k == 600) begin
                chk("run_pix601", 32'(pix_cnt), 32'd601);
                chk("run_mod_hold", 32'(mod), 32'd1);
                chkb("run_pe_mid", process_enable, 1'b1);
            end
        end
        mod_req_valid = 1'b0;
        frame_start = 1'b0;
        data_out_valid = 1'b0;
        chk("fd_early", 32'(fd_early), 32'd0);
        chkb("done_fd", frame_done, 1'b1);
        chkb("done_pe", process_enable, 1'b0);
        chkb("done_wiv", weight_in_valid, 1'b0);
        chk("done_pix", 32'(pix_cnt), 32'd1200);
        chk("done_mod", 32'(mod), 32'd1);
        step();
        load_check(3'b100);
        chkb("armed2_wiv", weight_in_valid, 1'b0);
        chk("armed2_mod", 32'(mod), 32'd4);
        chk("armed2_pix", 32'(pix_cnt), 32'd1200);
        step();
        chkb("armed2_stay_wiv", weight_in_valid, 1'b0);
        chkb("armed2_stay_pe", process_enable, 1'b0);
        chkb("armed2_stay_fd", frame_done, 1'b0);

        // pending request plus frame_start: the frame wins, then reset mid-frame
        mod_req = 3'b001;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chkb("prio_pe", process_enable, 1'b1);
        chk("prio_mod", 32'(mod), 32'd4);
        chkb("prio_ready", mod_req_ready, 1'b0);
        chk("prio_pix0", 32'(pix_cnt), 32'd0);
        for (int k = 0; k < 1000; k++) begin
            data_out_valid = 1'b1;
            step();
        end
        chk("pix1000", 32'(pix_cnt), 32'd1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        data_out_valid = 1'b0;
        check_reset_outputs();
        step();
        chkb("postrst_ready", mod_req_ready, 1'b1);
        chkb("postrst_fd", frame_done, 1'b0);
        step();
        chkb("postrst_no_load", weight_in_valid, 1'b0);

        // sharpen load, then disable from ARMED back to IDLE
        mod_req = 3'b010;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        step();
        load_check(3'b010);
        chk("armed3_mod", 32'(mod), 32'd2);
        mod_req = 3'b000;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        step();
        chk("off_mod", 32'(mod), 32'd0);
        chkb("off_wiv", weight_in_valid, 1'b0);
        chkb("off_ready", mod_req_ready, 1'b1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chkb("idle_ignores_fs", process_enable, 1'b0);

        // disable while already idle is simply consumed
        mod_req = 3'b000;
        mod_req_valid = 1'b1;
        step();
        mod_req_valid = 1'b0;
        step();
        chkb("idle_off_wiv", weight_in_valid, 1'b0);
        chkb("idle_off_ready", mod_req_ready, 1'b1);
        chk("idle_off_mod", 32'(mod), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_frame_scheduler.md
FILTER_FRAME_SCHEDULER -- requirements
Module: filter_frame_scheduler

Interface
REQ-001 Parameter COLS, default 640, pixels per line.
REQ-002 Parameter ROWS, default 480, lines per frame.
REQ-003 Parameter NTAPS, default 9, weight taps per kernel (3x3).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port mod_req  input  3  requested mode: 001 gaussian, 010 sharpen, 100 laplacian, 000 disable.
REQ-007 Port mod_req_valid  input  1  mode request strobe.
REQ-008 Port mod_req_ready  output  1  request accepted when valid&&ready.
REQ-009 Port frame_start  input  1  one-cycle pulse, first pixel of a source frame.
REQ-010 Port data_out_valid  input  1  output-pixel valid from the filter datapath.
REQ-011 Port mod  output  3  active mode driven to the datapath weight mux.
REQ-012 Port weight_in_valid  output  1  weight write strobe to the datapath.
REQ-013 Port weight_addr  output  4  weight tap index 0..NTAPS-1.
REQ-014 Port process_enable  output  1  datapath processing enable.
REQ-015 Port frame_done  output  1  one-cycle pulse at end of frame.
REQ-016 Port pix_cnt  output  clog2(COLS*ROWS)+1  output pixels counted in current frame.
REQ-017 Port err_illegal_mod  output  1  sticky: illegal mode code accepted.

Function
REQ-018 States IDLE, LOAD, ARMED, RUN, DONE; encoding registered, one state per cycle.
REQ-019 One-deep pending register (pend_valid, pend_mod); mod_req_ready = !pend_valid && state!=LOAD.
REQ-020 Accepted code not in {000,001,010,100}: dropped, pend unchanged, err_illegal_mod set next cycle.
REQ-021 IDLE: legal nonzero pending -> LOAD next cycle, mod <= pend_mod, pend_valid cleared; pending 000 consumed, stay IDLE.
REQ-022 Request accepted in IDLE is consumed the cycle after acceptance (2-cycle accept-to-LOAD latency).
REQ-023 LOAD: weight_in_valid=1 exactly NTAPS consecutive cycles, weight_addr 0,1,..,NTAPS-1; mod stable throughout; then ARMED.
REQ-024 ARMED: frame_start -> RUN next cycle, pix_cnt <= 0; legal nonzero pending (no frame_start same cycle) -> LOAD; pending 000 -> IDLE; frame_start wins over pending.
REQ-025 RUN: process_enable=1; pix_cnt += 1 per data_out_valid; frame_start ignored.
REQ-026 RUN: data_out_valid with pix_cnt==COLS*ROWS-1 -> DONE, pix_cnt reaches COLS*ROWS.
REQ-027 DONE: lasts one cycle, frame_done=1, process_enable=0; next: pending legal nonzero -> LOAD, pending 000 -> IDLE (mod <= 000), else ARMED.
REQ-028 Requests accepted during RUN take effect only at DONE; frame never interrupted by a mode change.
REQ-029 process_enable=0, weight_in_valid=0 in all states other than those stated; weight_addr=0 outside LOAD.
REQ-030 frame_done and weight_in_valid never high in the same cycle.

Reset
REQ-031 On rst at clock edge: state IDLE, mod 000, pend_valid 0, weight_in_valid 0, weight_addr 0, process_enable 0, frame_done 0, pix_cnt 0, err_illegal_mod 0.
REQ-032 rst mid-LOAD or mid-RUN aborts immediately; no frame_done pulse; pending request lost.
REQ-033 mod_req_ready=1 in the first cycle after reset release.

Structure
REQ-034 Shared package holds state encoding constants, mode codes (MOD_OFF, MOD_GAUSS, MOD_SHARP, MOD_LAPL) and the clog2 function.
REQ-035 Single module; no sub-module; pixel counter and tap counter inline.

Verification
REQ-036 Reset, mod_req=001 valid 1 cycle -> LOAD 2 cycles later, weight_addr 0..8 with weight_in_valid for 9 cycles, mod=001, then ARMED, process_enable=0.
REQ-037 ARMED, frame_start, 307200 data_out_valid (COLS=640, ROWS=480) -> process_enable high during RUN, pix_cnt=307200, frame_done one pulse, back to ARMED.
REQ-038 Mid-RUN mod_req=100 -> mod stays 001 until DONE, then LOAD with mod=100, 9 taps, ARMED; second request while pending -> mod_req_ready=0.
REQ-039 mod_req=011 accepted -> err_illegal_mod=1 sticky, state and mod unchanged; cleared only by rst.
REQ-040 rst asserted at pix_cnt=1000 in RUN -> next cycle all outputs at reset values, no frame_done; mod_req=000 in ARMED -> IDLE, mod=000.
